decode_stage: RTL and testbench

Registered, handshaked instruction-decode pipeline stage for the MIPS-subset core, a parametrised successor to the combinational decoder. It sits between the fetch queue and EX. Each cycle it accepts one instruction and its PC over a valid/ready link, decodes it into the ALU/control bundle plus a branch/jump target, and holds the result in an output register for EX. It also detects load-use hazards and inserts one bubble for each. A saturating stall counter supports performance debug.

---
 rtl/decode_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered valid/ready instruction-decode stage for the MIPS-subset core.
// Decodes into the ALU/control bundle, computes branch/jump targets and inserts one bubble per load-use hazard.
module decode_stage #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_instr,
    input  logic [DWIDTH-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_op,
    output logic              out_ssel,
    output logic [DWIDTH-1:0] out_imm,
    output logic [4:0]        out_rs1_id,
    output logic [4:0]        out_rs2_id,
    output logic [4:0]        out_rdst_id,
    output logic              out_we_regfile,
    output logic              out_we_dmem,
    output logic              out_mem_read,
    output logic              out_branch,
    output logic              out_jump,
    output logic              out_illegal,
    output logic [DWIDTH-1:0] out_target,
    output logic [DWIDTH-1:0] out_pc,
    output logic [CWIDTH-1:0] stall_count
);

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_UND = 4'b1111;

    localparam logic [CWIDTH-1:0] CNT_MAX = {CWIDTH{1'b1}};

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm16;
    logic [25:0]       addr26;
    logic [DWIDTH-1:0] pc4;
    logic [DWIDTH-1:0] simm;
    logic [DWIDTH-1:0] zimm;

    assign opcode = in_instr[31:26];
    assign rs     = in_instr[25:21];
    assign rt     = in_instr[20:16];
    assign rd     = in_instr[15:11];
    assign funct  = in_instr[5:0];
    assign imm16  = in_instr[15:0];
    assign addr26 = in_instr[25:0];
    assign pc4    = in_pc + DWIDTH'(4);
    assign simm   = {{(DWIDTH-16){imm16[15]}}, imm16};
    assign zimm   = {{(DWIDTH-16){1'b0}}, imm16};

    logic [3:0]        d_op;
    logic              d_ssel;
    logic [DWIDTH-1:0] d_imm;
    logic [4:0]        d_rdst;
    logic              d_we_regfile;
    logic              d_we_dmem;
    logic              d_mem_read;
    logic              d_branch;
    logic              d_jump;
    logic              d_illegal;
    logic [DWIDTH-1:0] d_target;

    // Instruction decode of the incoming word
    always_comb begin
        d_op         = ALU_UND;
        d_ssel       = 1'b0;
        d_imm        = '0;
        d_rdst       = 5'd0;
        d_we_regfile = 1'b0;
        d_we_dmem    = 1'b0;
        d_mem_read   = 1'b0;
        d_branch     = 1'b0;
        d_jump       = 1'b0;
        d_illegal    = 1'b0;
        d_target     = '0;
        case (opcode)
            OPC_RTYPE: begin
                d_ssel       = 1'b1;
                d_rdst       = rd;
                d_we_regfile = 1'b1;
                case (funct)
                    FN_ADD:  d_op = ALU_ADD;
                    FN_SUB:  d_op = ALU_SUB;
                    FN_AND:  d_op = ALU_AND;
                    FN_OR:   d_op = ALU_OR;
                    FN_NOR:  d_op = ALU_NOR;
                    FN_SLT:  d_op = ALU_SLT;
                    default: begin
                        d_op         = ALU_UND;
                        d_illegal    = 1'b1;
                        d_we_regfile = 1'b0;
                    end
                endcase
            end
            OPC_ADDI, OPC_SLTI, OPC_ANDI, OPC_ORI: begin
                d_rdst       = rt;
                d_we_regfile = 1'b1;
                case (opcode)
                    OPC_ADDI: begin d_op = ALU_ADD; d_imm = simm; end
                    OPC_SLTI: begin d_op = ALU_SLT; d_imm = simm; end
                    OPC_ANDI: begin d_op = ALU_AND; d_imm = zimm; end
                    default:  begin d_op = ALU_OR;  d_imm = zimm; end
                endcase
            end
            OPC_LW: begin
                d_op         = ALU_ADD;
                d_imm        = simm;
                d_rdst       = rt;
                d_we_regfile = 1'b1;
                d_mem_read   = 1'b1;
            end
            OPC_SW: begin
                d_op      = ALU_ADD;
                d_imm     = simm;
                d_we_dmem = 1'b1;
            end
            OPC_BEQ: begin
                d_op     = ALU_SUB;
                d_ssel   = 1'b1;
                d_branch = 1'b1;
                d_target = pc4 + (simm << 2);
            end
            OPC_J: begin
                d_op     = ALU_ADD;
                d_ssel   = 1'b1;
                d_jump   = 1'b1;
                d_target = {pc4[DWIDTH-1:28], addr26, 2'b00};
            end
            default: begin
                d_op      = ALU_UND;
                d_illegal = 1'b1;
            end
        endcase
    end

    // Load-use: a load sitting in the output register feeds a source of the incoming instruction
    logic uses_rt;
    logic hazard;
    logic capture;

    assign uses_rt = (opcode == OPC_RTYPE) || (opcode == OPC_SW) || (opcode == OPC_BEQ);
    assign hazard  = out_valid && out_mem_read && (out_rdst_id != 5'd0) && in_valid
                     && (((opcode != OPC_J) && (rs == out_rdst_id))
                         || (uses_rt && (rt == out_rdst_id)));
    assign in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid      <= 1'b0;
            out_op         <= 4'd0;
            out_ssel       <= 1'b0;
            out_imm        <= '0;
            out_rs1_id     <= 5'd0;
            out_rs2_id     <= 5'd0;
            out_rdst_id    <= 5'd0;
            out_we_regfile <= 1'b0;
            out_we_dmem    <= 1'b0;
            out_mem_read   <= 1'b0;
            out_branch     <= 1'b0;
            out_jump       <= 1'b0;
            out_illegal    <= 1'b0;
            out_target     <= '0;
            out_pc         <= '0;
            if (rst) begin
                stall_count <= '0;
            end
        end else begin
            if (capture) begin
                out_valid      <= 1'b1;
                out_op         <= d_op;
                out_ssel       <= d_ssel;
                out_imm        <= d_imm;
                out_rs1_id     <= rs;
                out_rs2_id     <= rt;
                out_rdst_id    <= d_rdst;
                out_we_regfile <= d_we_regfile;
                out_we_dmem    <= d_we_dmem;
                out_mem_read   <= d_mem_read;
                out_branch     <= d_branch;
                out_jump       <= d_jump;
                out_illegal    <= d_illegal;
                out_target     <= d_target;
                out_pc         <= in_pc;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (hazard && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + CWIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode results, handshake, load-use bubble, flush and stall counter.
module tb_decode_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;

    localparam logic [31:0] I_ADD3   = 32'h00221820; // add $3,$1,$2
    localparam logic [31:0] I_ADDI4  = 32'h2024FFFF; // addi $4,$1,-1
    localparam logic [31:0] I_LW5    = 32'h8C250000; // lw $5,0($1)
    localparam logic [31:0] I_ADD6_5 = 32'h00A23020; // add $6,$5,$2
    localparam logic [31:0] I_LW0    = 32'h8C200000; // lw $0,0($1)
    localparam logic [31:0] I_ADD6_0 = 32'h00023020; // add $6,$0,$2
    localparam logic [31:0] I_BEQ    = 32'h10220003; // beq $1,$2,3
    localparam logic [31:0] I_J      = 32'h08000040; // j 0x40
    localparam logic [31:0] I_ILL    = 32'hFC000000; // opcode 0x3F

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_instr = '0;
    logic [DW-1:0] in_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [3:0]    out_op;
    logic          out_ssel;
    logic [DW-1:0] out_imm;
    logic [4:0]    out_rs1_id, out_rs2_id, out_rdst_id;
    logic          out_we_regfile, out_we_dmem, out_mem_read, out_branch, out_jump, out_illegal;
    logic [DW-1:0] out_target;
    logic [DW-1:0] out_pc;
    logic [CW-1:0] stall_count;

    int n_checks = 0;
    int n_pass = 0;

    decode_stage #(.DWIDTH(DW), .CWIDTH(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_ssel(out_ssel),
        .out_imm(out_imm), .out_rs1_id(out_rs1_id), .out_rs2_id(out_rs2_id),
        .out_rdst_id(out_rdst_id), .out_we_regfile(out_we_regfile), .out_we_dmem(out_we_dmem),
        .out_mem_read(out_mem_read), .out_branch(out_branch), .out_jump(out_jump),
        .out_illegal(out_illegal), .out_target(out_target), .out_pc(out_pc),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (stall_count !== 3'd0) $display("FAIL rst_stall: got %0d exp 0", stall_count); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_ready: got %b exp 0", in_ready); else n_pass++;
        n_checks++; if (out_op !== 4'd0 || out_target !== 32'd0 || out_rdst_id !== 5'd0)
            $display("FAIL rst_bundle: got op=%b tgt=%h rdst=%0d exp 0", out_op, out_target, out_rdst_id); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rel_ready: got %b exp 1", in_ready); else n_pass++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = I_ADD3; in_pc = 32'h0;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_op !== 4'b0010 || out_ssel !== 1'b1 || out_rdst_id !== 5'd3)
            $display("FAIL b2b_add: got v=%b op=%b ssel=%b rdst=%0d exp 1/0010/1/3", out_valid, out_op, out_ssel, out_rdst_id); else n_pass++;
        n_checks++; if (out_we_regfile !== 1'b1 || out_imm !== 32'd0 || out_rs1_id !== 5'd1 || out_rs2_id !== 5'd2)
            $display("FAIL b2b_add_ctl: got we=%b imm=%h rs1=%0d rs2=%0d exp 1/0/1/2", out_we_regfile, out_imm, out_rs1_id, out_rs2_id); else n_pass++;
        in_instr = I_ADDI4; in_pc = 32'h4;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_op !== 4'b0010 || out_ssel !== 1'b0 || out_imm !== 32'hFFFFFFFF || out_rdst_id !== 5'd4)
            $display("FAIL b2b_addi: got v=%b op=%b ssel=%b imm=%h rdst=%0d exp 1/0010/0/ffffffff/4", out_valid, out_op, out_ssel, out_imm, out_rdst_id); else n_pass++;
        n_checks++; if (out_pc !== 32'h4) $display("FAIL b2b_pc: got %h exp 4", out_pc); else n_pass++;
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_load_use();
        in_valid = 1'b1; in_instr = I_LW5; in_pc = 32'h8;
        tick();
        n_checks++; if (out_mem_read !== 1'b1 || out_rdst_id !== 5'd5 || out_op !== 4'b0010)
            $display("FAIL lu_lw: got mr=%b rdst=%0d op=%b exp 1/5/0010", out_mem_read, out_rdst_id, out_op); else n_pass++;
        in_instr = I_ADD6_5; in_pc = 32'hC;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL lu_ready: got %b exp 0", in_ready); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0 || stall_count !== 3'd1)
            $display("FAIL lu_bubble: got v=%b cnt=%0d exp 0/1", out_valid, stall_count); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_rdst_id !== 5'd6 || out_pc !== 32'hC)
            $display("FAIL lu_dep: got v=%b rdst=%0d pc=%h exp 1/6/c", out_valid, out_rdst_id, out_pc); else n_pass++;
        in_instr = I_LW0; in_pc = 32'h10;
        tick();
        in_instr = I_ADD6_0; in_pc = 32'h14;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL lu0_ready: got %b exp 1", in_ready); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_rdst_id !== 5'd6 || stall_count !== 3'd1)
            $display("FAIL lu0_nobubble: got v=%b rdst=%0d cnt=%0d exp 1/6/1", out_valid, out_rdst_id, stall_count); else n_pass++;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = I_ADD3; in_pc = 32'h20;
        tick();
        in_instr = I_ADDI4; in_pc = 32'h24;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_rdst_id !== 5'd3 || out_pc !== 32'h20 || in_ready !== 1'b0)
                $display("FAIL hold_%0d: got v=%b rdst=%0d pc=%h rdy=%b exp 1/3/20/0", i, out_valid, out_rdst_id, out_pc, in_ready); else n_pass++;
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL hold_release: got %b exp 1", in_ready); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_rdst_id !== 5'd4 || out_pc !== 32'h24)
            $display("FAIL hold_next: got v=%b rdst=%0d pc=%h exp 1/4/24", out_valid, out_rdst_id, out_pc); else n_pass++;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_branch_jump();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = I_BEQ; in_pc = 32'h100;
        tick();
        n_checks++; if (out_target !== 32'h110 || out_op !== 4'b0110 || out_branch !== 1'b1 || out_ssel !== 1'b1)
            $display("FAIL beq: got tgt=%h op=%b br=%b ssel=%b exp 110/0110/1/1", out_target, out_op, out_branch, out_ssel); else n_pass++;
        n_checks++; if (out_imm !== 32'd0 || out_rdst_id !== 5'd0 || out_we_regfile !== 1'b0 || out_jump !== 1'b0)
            $display("FAIL beq_ctl: got imm=%h rdst=%0d we=%b j=%b exp 0/0/0/0", out_imm, out_rdst_id, out_we_regfile, out_jump); else n_pass++;
        in_instr = I_J; in_pc = 32'h00400000;
        tick();
        n_checks++; if (out_target !== 32'h00000100 || out_jump !== 1'b1 || out_op !== 4'b0010 || out_branch !== 1'b0)
            $display("FAIL jump: got tgt=%h j=%b op=%b br=%b exp 100/1/0010/0", out_target, out_jump, out_op, out_branch); else n_pass++;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal_flush();
        in_valid = 1'b1; in_instr = I_ILL; in_pc = 32'h200;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_op !== 4'b1111 || out_illegal !== 1'b1)
            $display("FAIL ill: got v=%b op=%b ill=%b exp 1/1111/1", out_valid, out_op, out_illegal); else n_pass++;
        n_checks++; if (out_we_regfile !== 1'b0 || out_we_dmem !== 1'b0 || out_mem_read !== 1'b0 || out_rdst_id !== 5'd0)
            $display("FAIL ill_ctl: got we=%b wd=%b mr=%b rdst=%0d exp 0/0/0/0", out_we_regfile, out_we_dmem, out_mem_read, out_rdst_id); else n_pass++;
        // hold a load stalled against a dependent, then flush
        in_instr = I_LW5; in_pc = 32'h204;
        tick();
        out_ready = 1'b0;
        in_instr = I_ADD6_5; in_pc = 32'h208; flush = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_ready: got %b exp 0", in_ready); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0 || out_rdst_id !== 5'd0 || stall_count !== 3'd1)
            $display("FAIL flush: got v=%b rdst=%0d cnt=%0d exp 0/0/1", out_valid, out_rdst_id, stall_count); else n_pass++;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_noacc: got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_saturate();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = I_LW5; in_pc = 32'h300;
        tick();
        in_instr = I_ADD6_5; in_pc = 32'h304;
        tick(); tick();
        n_checks++; if (stall_count !== 3'd3) $display("FAIL sat_mid: got %0d exp 3", stall_count); else n_pass++;
        for (int i = 0; i < 8; i++) tick();
        n_checks++; if (stall_count !== 3'd7) $display("FAIL sat_max: got %0d exp 7", stall_count); else n_pass++;
        in_valid = 1'b0; rst = 1'b1;
        tick();
        n_checks++; if (stall_count !== 3'd0 || out_valid !== 1'b0)
            $display("FAIL sat_rst: got cnt=%0d v=%b exp 0/0", stall_count, out_valid); else n_pass++;
        rst = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_hold();
        test_branch_jump();
        test_illegal_flush();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
